// File: rtl/gtp_blk_arb.sv
// Round-robin block arbiter: grants one source FIFO at a time and moves one complete
// block (CW dword + body) into a single 32-bit sink. Optional CW sanity check: GTP_ARB_CWCHECK_EN.
module gtp_blk_arb #(
  parameter int NSRC = 4,
  parameter int SRCW = 2
) (
  input  logic              gtp_clk,
  input  logic              rst,
  output logic [NSRC-1:0]   give,
  input  logic [NSRC-1:0]   have,
  input  logic [31:0]       data,
  input  logic              out_full,
  output logic              out_wr,
  output logic [31:0]       out_data,
  output logic [SRCW-1:0]   out_src,
  output logic              out_sob,
  output logic              out_eob,
  output logic              err_brk,
`ifdef GTP_ARB_CWCHECK_EN
  output logic              err_cw,
`endif
  output logic              busy
);

  typedef enum logic {POLL, BODY} state_t;

  state_t          state, state_nxt;
  logic [SRCW-1:0] ptr, ptr_nxt, src_nxt, sel;
  logic [7:0]      remaining, rem_nxt;
  logic            wr_nxt, sob_nxt, eob_nxt, brk_nxt;
`ifdef GTP_ARB_CWCHECK_EN
  logic            cw_nxt;
`endif

  function automatic logic [SRCW-1:0] next_idx(input logic [SRCW-1:0] idx);
    return (idx == SRCW'(NSRC - 1)) ? '0 : idx + SRCW'(1);
  endfunction

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    src_nxt   = out_src;
    rem_nxt   = remaining;
    wr_nxt    = 1'b0;
    sob_nxt   = 1'b0;
    eob_nxt   = 1'b0;
    brk_nxt   = 1'b0;
`ifdef GTP_ARB_CWCHECK_EN
    cw_nxt    = 1'b0;
`endif
    sel  = (state == BODY) ? out_src : ptr;
    give = '0;
    // A single select index keeps give one-hot, so the shared bus never sees two drivers.
    if (!rst && !out_full) give[sel] = 1'b1;

    case (state)
      POLL: begin
        if (!out_full) begin
          if (have[ptr]) begin
`ifdef GTP_ARB_CWCHECK_EN
            if (!data[15]) begin
              cw_nxt  = 1'b1;
              ptr_nxt = next_idx(ptr);
            end else
`endif
            begin
              wr_nxt  = 1'b1;
              sob_nxt = 1'b1;
              src_nxt = ptr;
              rem_nxt = data[8:1];
              if (data[8:1] == 8'd0) begin
                eob_nxt = 1'b1;
                ptr_nxt = next_idx(ptr);
              end else begin
                state_nxt = BODY;
              end
            end
          end else begin
            ptr_nxt = next_idx(ptr);
          end
        end
      end
      BODY: begin
        if (!out_full) begin
          if (have[out_src]) begin
            wr_nxt  = 1'b1;
            rem_nxt = remaining - 8'd1;
            if (remaining == 8'd1) begin
              eob_nxt   = 1'b1;
              ptr_nxt   = next_idx(out_src);
              state_nxt = POLL;
            end
          end else begin
            // Source ran dry mid-block: drop the rest and move on without an eob.
            brk_nxt   = 1'b1;
            ptr_nxt   = next_idx(out_src);
            state_nxt = POLL;
          end
        end
      end
      default: state_nxt = POLL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge gtp_clk) begin
    if (rst) begin
      state     <= POLL;
      ptr       <= '0;
      remaining <= '0;
      out_wr    <= 1'b0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_brk   <= 1'b0;
`ifdef GTP_ARB_CWCHECK_EN
      err_cw    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= rem_nxt;
      out_wr    <= wr_nxt;
      out_sob   <= sob_nxt;
      out_eob   <= eob_nxt;
      out_src   <= src_nxt;
      err_brk   <= brk_nxt;
`ifdef GTP_ARB_CWCHECK_EN
      err_cw    <= cw_nxt;
`endif
      if (wr_nxt) out_data <= data;
    end
  end

  assign busy = (state == BODY);

endmodule

// File: tb/tb_gtp_blk_arb.sv
// Directed bench for gtp_blk_arb: behavioural source FIFOs on the give/have bus,
// a write monitor, and one task per scenario with inline comparisons.
module tb_gtp_blk_arb;
  localparam int NSRC = 4;
  localparam int SRCW = 2;

  logic gtp_clk = 1'b0;
  logic rst = 1'b1;
  logic out_full = 1'b0;
  logic clr = 1'b0;
  logic [NSRC-1:0] give, have;
  logic [31:0] data, out_data;
  logic [SRCW-1:0] out_src;
  logic out_wr, out_sob, out_eob, err_brk, busy;
`ifdef GTP_ARB_CWCHECK_EN
  logic err_cw;
`endif

  gtp_blk_arb #(.NSRC(NSRC), .SRCW(SRCW)) dut (
    .gtp_clk(gtp_clk), .rst(rst), .give(give), .have(have), .data(data),
    .out_full(out_full), .out_wr(out_wr), .out_data(out_data), .out_src(out_src),
    .out_sob(out_sob), .out_eob(out_eob), .err_brk(err_brk),
`ifdef GTP_ARB_CWCHECK_EN
    .err_cw(err_cw),
`endif
    .busy(busy));

  always #5 gtp_clk = ~gtp_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Source FIFO model: answers give[i] combinationally while it still has dwords
  // and has not reached its cut point.
  logic [31:0] mem [NSRC][16];
  int len [NSRC];
  int cut [NSRC];
  int rd  [NSRC];

  always_comb begin
    have = '0;
    data = 32'hDEAD_BEEF;
    for (int i = 0; i < NSRC; i++)
      if (give[i] && rd[i] < len[i] && rd[i] < cut[i]) begin
        have[i] = 1'b1;
        data    = mem[i][rd[i]];
      end
  end

  always @(posedge gtp_clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NSRC; i++)
      if (clr) rd[i] <= 0;
      else if (give[i] && have[i]) rd[i] <= rd[i] + 1;
  end

  typedef struct {
    logic [31:0]     d;
    logic [SRCW-1:0] src;
    logic            sob;
    logic            eob;
    logic [NSRC-1:0] g;
    int              c;
  } wr_t;
  wr_t wr_q[$];

  always @(negedge gtp_clk)
    if (out_wr) wr_q.push_back('{out_data, out_src, out_sob, out_eob, give, cyc});

  function automatic logic [31:0] word(input int s, input int k, input logic [15:0] cw);
    return (k == 0) ? {8'hC0, 8'(s), cw} : {8'hB0, 8'(s), 8'(k), 8'h5A};
  endfunction

  task automatic load_block(input int s, input logic [15:0] cw, input int n, input int cut_at);
    for (int k = 0; k < n; k++) mem[s][k] = word(s, k, cw);
    len[s] = n;
    cut[s] = cut_at;
  endtask

  // Leaves rst high at a falling edge with all sources empty and read pointers cleared.
  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      len[i] = 0;
      cut[i] = 99;
    end
    repeat (2) @(negedge gtp_clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (give !== 4'b0000) begin n_fail++; $display("FAIL rst_give: got %b want 0000", give); end
    n_checks++; if ({out_wr, out_sob, out_eob} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {out_wr, out_sob, out_eob}); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
    n_checks++; if ({err_brk, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_brk_busy: got %b want 00", {err_brk, busy}); end
`ifdef GTP_ARB_CWCHECK_EN
    n_checks++; if (err_cw !== 1'b0) begin n_fail++; $display("FAIL rst_err_cw: got %b want 0", err_cw); end
`endif
  endtask

  task automatic test_single_block();
    int base;
    wr_t w;
    do_reset();
    load_block(1, 16'h8207, 4, 99);
    base = wr_q.size();
    rst = 1'b0;
    #1;
    n_checks++; if (give !== 4'b0001) begin n_fail++; $display("FAIL blk_poll0: got %b want 0001", give); end
    @(negedge gtp_clk); #1;
    n_checks++; if (give !== 4'b0010) begin n_fail++; $display("FAIL blk_poll1: got %b want 0010", give); end
    n_checks++; if (out_wr !== 1'b0) begin n_fail++; $display("FAIL blk_nowr_empty: got %b want 0", out_wr); end
    repeat (6) @(negedge gtp_clk); #1;
    n_checks++; if (wr_q.size() - base != 4) begin n_fail++; $display("FAIL blk_count: got %0d want 4", wr_q.size() - base); end
    for (int k = 0; k < 4; k++) if (base + k < wr_q.size()) begin
      w = wr_q[base + k];
      n_checks++; if (w.d !== word(1, k, 16'h8207)) begin n_fail++; $display("FAIL blk_data[%0d]: got %h want %h", k, w.d, word(1, k, 16'h8207)); end
      n_checks++; if ({w.src, w.sob, w.eob} !== {2'd1, k == 0, k == 3}) begin n_fail++; $display("FAIL blk_tags[%0d]: got src=%0d sob=%b eob=%b", k, w.src, w.sob, w.eob); end
      n_checks++; if (w.c != wr_q[base].c + k) begin n_fail++; $display("FAIL blk_consec[%0d]: got cycle %0d want %0d", k, w.c, wr_q[base].c + k); end
    end
    if (wr_q.size() >= base + 4) begin
      n_checks++; if (wr_q[base].d[15:0] !== 16'h8207) begin n_fail++; $display("FAIL blk_cw: got %h want 8207", wr_q[base].d[15:0]); end
      n_checks++; if (wr_q[base + 3].g !== 4'b0100) begin n_fail++; $display("FAIL blk_next_poll: got %b want 0100", wr_q[base + 3].g); end
    end
  endtask

  task automatic test_two_singles();
    int base;
    do_reset();
    load_block(0, 16'h8001, 1, 99);
    load_block(2, 16'h8001, 1, 99);
    base = wr_q.size();
    out_full = 1'b1;
    rst = 1'b0;
    repeat (3) begin
      #1;
      n_checks++; if (give !== 4'b0000) begin n_fail++; $display("FAIL poll_full_give: got %b want 0000", give); end
      @(negedge gtp_clk);
    end
    out_full = 1'b0;
    #1;
    n_checks++; if (give !== 4'b0001) begin n_fail++; $display("FAIL poll_ptr_held: got %b want 0001", give); end
    repeat (6) @(negedge gtp_clk); #1;
    n_checks++; if (wr_q.size() - base != 2) begin n_fail++; $display("FAIL single_count: got %0d want 2", wr_q.size() - base); end
    if (wr_q.size() >= base + 2) begin
      n_checks++; if ({wr_q[base].src, wr_q[base].sob, wr_q[base].eob, wr_q[base].d} !== {2'd0, 2'b11, word(0, 0, 16'h8001)})
        begin n_fail++; $display("FAIL single0: got src=%0d sob=%b eob=%b d=%h", wr_q[base].src, wr_q[base].sob, wr_q[base].eob, wr_q[base].d); end
      n_checks++; if ({wr_q[base+1].src, wr_q[base+1].sob, wr_q[base+1].eob, wr_q[base+1].d} !== {2'd2, 2'b11, word(2, 0, 16'h8001)})
        begin n_fail++; $display("FAIL single2: got src=%0d sob=%b eob=%b d=%h", wr_q[base+1].src, wr_q[base+1].sob, wr_q[base+1].eob, wr_q[base+1].d); end
      n_checks++; if (wr_q[base+1].c - wr_q[base].c != 2) begin n_fail++; $display("FAIL single_gap: got %0d want 2", wr_q[base+1].c - wr_q[base].c); end
      n_checks++; if (wr_q[base+1].g !== 4'b1000) begin n_fail++; $display("FAIL single_next_poll: got %b want 1000", wr_q[base+1].g); end
    end
  endtask

  task automatic test_stall();
    int base, t;
    wr_t w;
    do_reset();
    load_block(3, 16'h8012, 10, 99);
    base = wr_q.size();
    rst = 1'b0;
    t = 0;
    while (wr_q.size() - base < 4 && t < 30) begin @(negedge gtp_clk); #1; t++; end
    n_checks++; if (wr_q.size() - base != 4) begin n_fail++; $display("FAIL stall_reach4: got %0d want 4", wr_q.size() - base); end
    out_full = 1'b1;
    repeat (3) begin
      #1;
      n_checks++; if ({give, busy} !== 5'b00001) begin n_fail++; $display("FAIL stall_give: got give=%b busy=%b want 0000/1", give, busy); end
      @(negedge gtp_clk); #1;
      n_checks++; if (out_wr !== 1'b0) begin n_fail++; $display("FAIL stall_wr: got %b want 0", out_wr); end
    end
    out_full = 1'b0;
    repeat (12) @(negedge gtp_clk); #1;
    n_checks++; if (wr_q.size() - base != 10) begin n_fail++; $display("FAIL stall_count: got %0d want 10", wr_q.size() - base); end
    for (int k = 0; k < 10; k++) if (base + k < wr_q.size()) begin
      w = wr_q[base + k];
      n_checks++; if ({w.d, w.src, w.sob, w.eob} !== {word(3, k, 16'h8012), 2'd3, k == 0, k == 9})
        begin n_fail++; $display("FAIL stall_wr[%0d]: got d=%h src=%0d sob=%b eob=%b", k, w.d, w.src, w.sob, w.eob); end
    end
    if (wr_q.size() >= base + 10) begin
      n_checks++; if (wr_q[base+4].c - wr_q[base+3].c != 4) begin n_fail++; $display("FAIL stall_gap: got %0d want 4", wr_q[base+4].c - wr_q[base+3].c); end
      n_checks++; if (wr_q[base+9].g !== 4'b0001) begin n_fail++; $display("FAIL stall_wrap: got %b want 0001", wr_q[base+9].g); end
    end
  endtask

  task automatic test_break();
    int base, t;
    do_reset();
    load_block(0, 16'h8008, 5, 2);
    base = wr_q.size();
    rst = 1'b0;
    t = 0;
    while (err_brk !== 1'b1 && t < 20) begin @(negedge gtp_clk); t++; end
    n_checks++; if (err_brk !== 1'b1) begin n_fail++; $display("FAIL brk_seen: got %b want 1", err_brk); end
    n_checks++; if ({give, busy} !== 5'b00100) begin n_fail++; $display("FAIL brk_resume: got give=%b busy=%b want 0010/0", give, busy); end
    @(negedge gtp_clk);
    n_checks++; if (err_brk !== 1'b0) begin n_fail++; $display("FAIL brk_pulse: got %b want 0", err_brk); end
    repeat (2) @(negedge gtp_clk); #1;
    n_checks++; if (wr_q.size() - base != 2) begin n_fail++; $display("FAIL brk_count: got %0d want 2", wr_q.size() - base); end
    if (wr_q.size() >= base + 2) begin
      n_checks++; if ({wr_q[base].sob, wr_q[base].eob, wr_q[base+1].sob, wr_q[base+1].eob} !== 4'b1000)
        begin n_fail++; $display("FAIL brk_tags: got %b want 1000", {wr_q[base].sob, wr_q[base].eob, wr_q[base+1].sob, wr_q[base+1].eob}); end
      n_checks++; if (wr_q[base+1].d !== word(0, 1, 16'h8008)) begin n_fail++; $display("FAIL brk_data: got %h want %h", wr_q[base+1].d, word(0, 1, 16'h8008)); end
    end
  endtask

  task automatic test_mid_reset();
    int base, t;
    do_reset();
    load_block(0, 16'h800A, 6, 99);
    base = wr_q.size();
    rst = 1'b0;
    t = 0;
    while (wr_q.size() - base < 3 && t < 20) begin @(negedge gtp_clk); #1; t++; end
    rst = 1'b1;
    @(negedge gtp_clk); #1;
    n_checks++; if ({out_wr, give, busy} !== 6'b0) begin n_fail++; $display("FAIL mrst_idle: got wr=%b give=%b busy=%b want 0", out_wr, give, busy); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mrst_data: got %h want 0", out_data); end
    n_checks++; if (wr_q.size() - base != 3) begin n_fail++; $display("FAIL mrst_count: got %0d want 3", wr_q.size() - base); end
    clr = 1'b1;
    @(negedge gtp_clk);
    clr = 1'b0;
    load_block(0, 16'h8002, 2, 99);
    base = wr_q.size();
    rst = 1'b0;
    #1;
    n_checks++; if (give !== 4'b0001) begin n_fail++; $display("FAIL mrst_ptr0: got %b want 0001", give); end
    repeat (5) @(negedge gtp_clk); #1;
    n_checks++; if (wr_q.size() - base != 2) begin n_fail++; $display("FAIL mrst_new_count: got %0d want 2", wr_q.size() - base); end
    if (wr_q.size() >= base + 2) begin
      n_checks++; if ({wr_q[base].d, wr_q[base].sob, wr_q[base+1].d, wr_q[base+1].eob} !== {word(0, 0, 16'h8002), 1'b1, word(0, 1, 16'h8002), 1'b1})
        begin n_fail++; $display("FAIL mrst_new_blk: got %h/%b %h/%b", wr_q[base].d, wr_q[base].sob, wr_q[base+1].d, wr_q[base+1].eob); end
    end
  endtask

`ifdef GTP_ARB_CWCHECK_EN
  task automatic test_cwcheck();
    int base;
    do_reset();
    mem[2][0] = 32'h0000_1234;
    len[2] = 1;
    base = wr_q.size();
    rst = 1'b0;
    repeat (2) @(negedge gtp_clk); #1;
    n_checks++; if (give !== 4'b0100) begin n_fail++; $display("FAIL cw_poll2: got %b want 0100", give); end
    @(negedge gtp_clk); #1;
    n_checks++; if ({err_cw, out_wr, give} !== 6'b101000) begin n_fail++; $display("FAIL cw_reject: got err_cw=%b wr=%b give=%b", err_cw, out_wr, give); end
    @(negedge gtp_clk); #1;
    n_checks++; if (err_cw !== 1'b0) begin n_fail++; $display("FAIL cw_pulse: got %b want 0", err_cw); end
    n_checks++; if (wr_q.size() != base) begin n_fail++; $display("FAIL cw_nowrite: got %0d writes want 0", wr_q.size() - base); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_block();
    test_two_singles();
    test_stall();
    test_break();
    test_mid_reset();
`ifdef GTP_ARB_CWCHECK_EN
    test_cwcheck();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gtp_blk_arb.md
Name: gtp_blk_arb

Overview:
- Round-robin block arbiter downstream of NSRC per-link block FIFOs (give/have/tri-state data protocol), one clock domain gtp_clk.
- Polls each FIFO and transfers exactly one complete block (CW dword + body) per grant into a single 32-bit sink (MIG write path).
- Never interleaves blocks from different sources.

Parameters:
- NSRC, 4, number of source FIFOs (2..8).
- SRCW, 2, width of source index; must satisfy 2**SRCW >= NSRC.

Ports:
- gtp_clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- give  out  NSRC  one-hot read request to source i; at most one bit set per cycle.
- have  in  NSRC  source i returns a valid dword this cycle (combinational response to give[i]).
- data  in  32  shared tri-state data bus from all sources; valid only when have[i] and give[i].
- out_full  in  1  sink cannot guarantee 2 more free entries.
- out_wr  out  1  registered sink write strobe.
- out_data  out  32  registered sink write data.
- out_src  out  SRCW  source index of the block being written (stable for the whole block).
- out_sob  out  1  registered with out_wr, marks the CW dword.
- out_eob  out  1  registered with out_wr, marks the last dword of the block.
- err_brk  out  1  one-cycle pulse: have dropped mid-block.
- busy  out  1  high in BODY state.

Behaviour:
- Reset (rst=1 at edge): state=POLL, ptr=0, give=0, out_wr=0, out_sob=0, out_eob=0, out_data=0, out_src=0, err_brk=0, remaining=0. Reset mid-block abandons the transfer; no further writes.
- CW dword layout: bits[15:0] = CW (1 CCCCCC LLLLLLLLL), bits[31:16] = first body word or filler. Total block dwords = L[8:1]+1; remaining after CW = data[8:1] (8 bits).
- POLL:
  - If out_full=0: give[ptr]=1 (combinational).
  - If have[ptr]=1 same cycle: capture data as CW, out_src<=ptr, remaining<=data[8:1], and register write with sob=1.
    - If data[8:1]==0: eob=1 on the same write, ptr<=ptr+1 (wrap NSRC-1→0), stay POLL.
    - Else go to BODY.
  - If have[ptr]=0: ptr<=ptr+1 (wrap), no write.
  - If out_full=1: give=0, ptr holds.
- BODY:
  - give[out_src]=1 whenever out_full=0; each cycle with have=1 writes data and decrements remaining.
  - When remaining==1 and have=1: that write carries eob=1, ptr<=out_src+1 (wrap), go to POLL.
  - If give asserted and have=0: err_brk pulse, out_wr=0, ptr<=out_src+1, go to POLL (block truncated; no eob emitted).
  - out_full=1: give=0, pause; remaining unchanged.
- Latency: data on bus at cycle n appears on out_data/out_wr at cycle n+1.
- Throughput: 1 dword/cycle while out_full=0.
- Sink must absorb one write issued in the cycle after it raises out_full.
- give is never asserted to more than one source; tri-state bus contention is impossible by construction.
- out_wr, out_sob, out_eob are default 0 each cycle unless a write occurs.

Optional Feature:
- GTP_ARB_CWCHECK_EN:
  - Defined: in POLL, a captured dword with data[15]==0 is not written. It pulses err_cw (extra 1-bit output, 0 at reset), advances ptr, and stays POLL. The source's remaining body dwords are left for the next grant and will fail the check again.
  - Undefined: no check, no err_cw port; every captured dword is treated as CW.

Test Plan:
- Source 1 holds block CW=0x8207 (L=7 → 4 dwords), others empty, out_full=0 → polls 0,1; four consecutive out_wr; sob on first with out_data[15:0]=0x8207; eob on 4th; out_src=1; next poll at source 2.
- Sources 0 and 2 each hold a 1-dword block (CW 0x8001) → two single writes, each with sob=eob=1; out_src 0 then 2; no interleave.
- Block of 10 dwords from source 3; out_full raised for 3 cycles after 4th dword → give=0 during stall; exactly 10 writes total with one extra post-full write allowed; eob on 10th.
- Source 0 drops have after 2 of 5 dwords → err_brk one-cycle pulse; 2 writes, no eob; arbiter resumes polling at source 1.
- rst asserted at 3rd dword of a 6-dword block → next cycle out_wr=0, give=0, ptr=0; after release a new block from source 0 transfers cleanly.
- With GTP_ARB_CWCHECK_EN: source 2 presents 0x00001234 in POLL → no write, err_cw=1 for one cycle, ptr→3.
